// File: rtl/if_pc_gen.sv
// if_pc_gen -- instruction-fetch PC generator and fetch sequencer (IF stage).
//
// Presents the current fetch PC to the branch predictor and to instruction
// memory, chooses the next PC from the predictor answer and redirects to the
// flush PC on a misprediction reported by ID. Fetched instructions are handed
// to IF/ID through a single-entry valid/ready output buffer.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   if_predict_pc_o               PC under predictor lookup (= pc register)
//   if_predict_taken_i            predictor taken for if_predict_pc_o
//   if_predict_targetPc_i         predicted target for if_predict_pc_o
//   if_predict_failed_i           misprediction from ID, redirect required
//   if_flush_pc_i                 redirect address
//   inst_req_o, inst_addr_o       fetch request / address
//   inst_ready_i                  memory accepts the request this cycle
//   inst_rvalid_i, inst_rdata_i   response, one cycle after acceptance
//   if_valid_o, if_pc_o, if_inst_o,
//   if_pred_taken_o, if_pred_targetPc_o   output buffer contents
//   id_ready_i                    ID consumes the buffer this cycle
//
// Optional feature: define IF_PCGEN_ALIGN_CHECK_EN to treat a predicted
// target with nonzero bits [1:0] as not-taken.

`ifndef RegW
`define RegW 32
`endif

module if_pc_gen #(
    parameter logic [`RegW-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [`RegW-1:0]  if_predict_pc_o,
    input  logic              if_predict_taken_i,
    input  logic [`RegW-1:0]  if_predict_targetPc_i,
    input  logic              if_predict_failed_i,
    input  logic [`RegW-1:0]  if_flush_pc_i,
    output logic              inst_req_o,
    output logic [`RegW-1:0]  inst_addr_o,
    input  logic              inst_ready_i,
    input  logic              inst_rvalid_i,
    input  logic [31:0]       inst_rdata_i,
    output logic              if_valid_o,
    output logic [`RegW-1:0]  if_pc_o,
    output logic [31:0]       if_inst_o,
    output logic              if_pred_taken_o,
    output logic [`RegW-1:0]  if_pred_targetPc_o,
    input  logic              id_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [`RegW-1:0]  pc, pc_next;
    logic              kill, kill_next;

    // in-flight tag
    logic [`RegW-1:0]  tag_pc;
    logic              tag_taken;
    logic [`RegW-1:0]  tag_target;

    // output buffer
    logic              buf_valid;
    logic [`RegW-1:0]  buf_pc;
    logic [31:0]       buf_inst;
    logic              buf_taken;
    logic [`RegW-1:0]  buf_target;

    logic              space;
    logic              resp;
    logic              redirect;
    logic              resp_keep;
    logic              replay;
    logic              req;
    logic              accept;
    logic              pred_taken;
    logic [`RegW-1:0]  seq_pc;

    always_comb begin
        space     = ~buf_valid | id_ready_i;
        resp      = (state == WAIT) & inst_rvalid_i;
        redirect  = (state != IDLE) & if_predict_failed_i;
        resp_keep = resp & ~kill & ~redirect;
        // A live response that finds the buffer full and unconsumed cannot be
        // stored; rewind pc to its address so it is fetched again instead of
        // being lost.
        replay    = resp_keep & ~space;
        // Only one request outstanding: in WAIT a new one may issue only in
        // the cycle the pending response returns.
        req       = ((state == RUN) | resp) & space & ~if_predict_failed_i;
        accept    = req & inst_ready_i;

`ifdef IF_PCGEN_ALIGN_CHECK_EN
        pred_taken = if_predict_taken_i & (if_predict_targetPc_i[1:0] == 2'b00);
`else
        pred_taken = if_predict_taken_i;
`endif
        seq_pc = pred_taken ? if_predict_targetPc_i : pc + `RegW'(4);
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        kill_next  = kill;

        case (state)
            IDLE: state_next = RUN;
            RUN:  state_next = accept ? WAIT : RUN;
            WAIT: begin
                if (redirect) begin
                    if (inst_rvalid_i) begin
                        state_next = RUN;
                        kill_next  = 1'b0;
                    end else begin
                        kill_next  = 1'b1;
                    end
                end else if (resp) begin
                    state_next = accept ? WAIT : RUN;
                    kill_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        if (redirect)
            pc_next = if_flush_pc_i;
        else if (replay)
            pc_next = tag_pc;
        else if (accept)
            pc_next = seq_pc;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            tag_pc     <= '0;
            tag_taken  <= 1'b0;
            tag_target <= '0;
            buf_valid  <= 1'b0;
            buf_pc     <= '0;
            buf_inst   <= '0;
            buf_taken  <= 1'b0;
            buf_target <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            kill  <= kill_next;

            if (accept) begin
                tag_pc     <= pc;
                tag_taken  <= pred_taken;
                tag_target <= if_predict_targetPc_i;
            end

            if (redirect) begin
                buf_valid <= 1'b0;
            end else if (resp_keep & space) begin
                buf_valid  <= 1'b1;
                buf_pc     <= tag_pc;
                buf_inst   <= inst_rdata_i;
                buf_taken  <= tag_taken;
                buf_target <= tag_target;
            end else if (buf_valid & id_ready_i) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign if_predict_pc_o    = pc;
    assign inst_addr_o        = pc;
    assign inst_req_o         = req;
    assign if_valid_o         = buf_valid;
    assign if_pc_o            = buf_pc;
    assign if_inst_o          = buf_inst;
    assign if_pred_taken_o    = buf_taken;
    assign if_pred_targetPc_o = buf_target;

endmodule

// File: doc/if_pc_gen.md
# if_pc_gen

Instruction-fetch PC generator and fetch sequencer for the IF stage. Each cycle it presents the current fetch PC to the branch predictor and to instruction memory. It selects the next PC from the predictor's taken/target answer and redirects to the predictor's flush PC when ID reports a misprediction. The fetched instruction, its PC and the prediction used are handed to the IF/ID register through a single-entry output buffer with valid/ready flow control.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- if_predict_pc_o  out  `RegW  PC sent to the predictor for lookup; equals the internal pc register.
- if_predict_taken_i  in  1  predictor says taken for if_predict_pc_o (combinational, same cycle).
- if_predict_targetPc_i  in  `RegW  predicted target for if_predict_pc_o.
- if_predict_failed_i  in  1  ID found a misprediction; redirect required.
- if_flush_pc_i  in  `RegW  redirect address, valid when if_predict_failed_i=1.
- inst_req_o  out  1  fetch request.
- inst_addr_o  out  `RegW  fetch address; equals pc.
- inst_ready_i  in  1  memory accepts the request this cycle.
- inst_rvalid_i  in  1  response data valid; arrives exactly one cycle after acceptance.
- inst_rdata_i  in  32  instruction word.
- if_valid_o  out  1  output buffer holds an instruction.
- if_pc_o  out  `RegW  PC of the buffered instruction.
- if_inst_o  out  32  buffered instruction.
- if_pred_taken_o  out  1  prediction used for the buffered instruction.
- if_pred_targetPc_o  out  `RegW  predicted target carried to ID for checking.
- id_ready_i  in  1  ID consumes the buffer this cycle when if_valid_o=1.

## Operation
- State: pc, fsm {IDLE, RUN, WAIT}, and the in-flight tag (pc, taken, target, kill bit).
- The output buffer holds one entry: valid, pc, inst, taken, target.
- Reset: pc=RESET_PC, fsm=IDLE, kill=0, and all outputs 0 except if_predict_pc_o/inst_addr_o=RESET_PC.
- IDLE: no request. Moves to RUN on the next cycle.
- "Space" means the buffer will be empty next cycle: ~if_valid_o | id_ready_i.
- RUN: inst_req_o = space & ~if_predict_failed_i.
  - On acceptance (req & inst_ready_i), the tag captures {pc, taken, target}, pc <= taken ? target : pc+4, and fsm moves to WAIT.
- WAIT: when inst_rvalid_i arrives and kill=0, the buffer loads {tag.pc, inst_rdata_i, tag.taken, tag.target}. If kill=1, the response is dropped.
  - In the same cycle, a new request may issue under the RUN rule. If it is accepted, fsm stays WAIT; otherwise fsm goes to RUN.
- Redirect (if_predict_failed_i=1) has the highest priority in any state except IDLE:
  - pc <= if_flush_pc_i.
  - The buffer is invalidated, regardless of id_ready_i.
  - No request issues that cycle.
  - In WAIT with no rvalid this cycle, kill <= 1. A response arriving this same cycle is dropped.
  - kill clears when the killed response arrives.
- The buffer holds its contents while if_valid_o & ~id_ready_i. It is cleared on consume unless reloaded in the same cycle.
- pc+4 wraps modulo 2^`RegW`.

## Timing
- Predictor lookup is combinational. taken/target are sampled on the acceptance edge.
- With inst_ready_i=1 and id_ready_i=1, throughput is 1 instruction/cycle. Latency is 2 cycles from the acceptance edge to if_valid_o.
- At most one request is outstanding.
- First request after reset: cycle 2, at RESET_PC.
- A redirect in cycle N gives a request for the flush PC in cycle N+1 (given space and ready). The corresponding instruction is valid at N+3.
- A simultaneous redirect and consume: the redirect wins, and the buffer is empty next cycle.
- Reset mid-WAIT: the pending response is ignored, because fsm is IDLE for one cycle and inst_rvalid_i is disregarded outside WAIT.

## Configuration
- IF_PCGEN_ALIGN_CHECK_EN:
  - Defined: a predicted target whose bits [1:0] are nonzero is treated as not-taken. Next pc is pc+4, and the recorded taken is 0.
  - Undefined: the predicted target is used verbatim.

## Test plan
- Reset, ready always 1, predictor not-taken → requests at 0x8000_0000, 0x8000_0004, 0x8000_0008 in consecutive cycles. if_valid_o is 1 from cycle 4 onward.
- Predictor taken at 0x8000_0008 with target 0x8000_0040 → the next request address is 0x8000_0040. The buffered entry for 0x8000_0008 has if_pred_taken_o=1 and if_pred_targetPc_o=0x8000_0040.
- Hold id_ready_i=0 for 3 cycles with the buffer full → if_inst_o stays stable and inst_req_o=0. Release → fetch resumes at the next PC with no duplicate or lost instruction.
- Redirect to 0x8000_0100 while in WAIT → the in-flight response is dropped and if_valid_o=0. The next request is 0x8000_0100 and its instruction appears 3 cycles after the redirect.
- inst_ready_i=0 for 2 cycles → inst_req_o stays 1 with a stable inst_addr_o, and acceptance occurs on the third cycle.
- With IF_PCGEN_ALIGN_CHECK_EN defined, a taken prediction with target 0x8000_0042 from pc 0x8000_0010 → next request 0x8000_0014 and if_pred_taken_o=0.
